// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline types: fetch FSM states and the IF/ID register payload.
package rv_pkg;

    localparam int RV_XLEN    = 64;
    localparam int INST_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        KILL
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        inst;
        logic [RV_XLEN-1:0] pc;
    } if_id_regs_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory port: valid/ready request channel plus valid-only response channel.
// The master side is the fetch controller, the slave side is the instruction memory.
interface fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [31:0]       rsp_inst;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_inst
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_inst
    );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: consumed instructions, stalled HOLD cycles and
// discarded responses. All three are free-running and wrap at 2^32.
module fetch_perf_cnt (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetched,
    input  logic        i_stalled,
    input  logic        i_killed,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_stall,
    output logic [31:0] o_perf_killed
);

    logic [31:0] fetched_q;
    logic [31:0] stall_q;
    logic [31:0] killed_q;

    // Count each event pulse; natural 32-bit overflow provides the wrap.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
            killed_q  <= '0;
        end else begin
            if (i_fetched) fetched_q <= fetched_q + 32'd1;
            if (i_stalled) stall_q   <= stall_q + 32'd1;
            if (i_killed)  killed_q  <= killed_q + 32'd1;
        end
    end

    assign o_perf_fetched = fetched_q;
    assign o_perf_stall   = stall_q;
    assign o_perf_killed  = killed_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer. Owns the fetch PC, issues one imem request at a
// time, applies flush redirects (highest priority) and drops stale responses,
// and holds the fetched instruction while the ID stage stalls.
// Optional macro FETCH_PERF_EN adds the o_perf_* counter outputs.
module fetch_ctrl
    import rv_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              ADDR_W   = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_flush_valid,
    input  logic [XLEN-1:0] i_flush_target,
    fetch_ctrl_if.master    imem,
    output logic            o_if_valid,
    output if_id_regs_t     o_if_id_regs,
    output logic            o_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     o_perf_fetched,
    output logic [31:0]     o_perf_stall,
    output logic [31:0]     o_perf_killed
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] flush_pc;
    logic            req_fire;
    logic            if_load;
    logic            if_clear;
    logic            rsp_discard;

    // Masking the low bits keeps the redirect PC word aligned.
    assign flush_pc = i_flush_target & ~XLEN'(INST_BYTES - 1);
    assign req_fire = imem.req_valid && imem.req_ready;

    assign imem.req_valid = (state_q == REQ);
    assign imem.req_addr  = fetch_pc_q[ADDR_W-1:0];
    assign o_busy         = (state_q == WAIT) || (state_q == KILL);

    // Next-state and PC update logic; a flush overrides the normal transition.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        if_load       = 1'b0;
        if_clear      = 1'b0;
        rsp_discard   = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_fire) begin
                    inflight_pc_d = fetch_pc_q;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    if_load    = 1'b1;
                    fetch_pc_d = inflight_pc_q + XLEN'(INST_BYTES);
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (!i_stall) begin
                    if_clear = 1'b1;
                    state_d  = REQ;
                end
            end
            KILL: begin
                if (imem.rsp_valid) begin
                    rsp_discard = 1'b1;
                    state_d     = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_flush_valid) begin
            fetch_pc_d = flush_pc;
            if_load    = 1'b0;
            if_clear   = 1'b1;
            case (state_q)
                // An accepted request still owes a response, so it must be killed.
                REQ:  state_d = req_fire ? KILL : REQ;
                WAIT: begin
                    rsp_discard = imem.rsp_valid;
                    state_d     = imem.rsp_valid ? REQ : KILL;
                end
                KILL: state_d = imem.rsp_valid ? REQ : KILL;
                default: state_d = REQ;
            endcase
        end
    end

    // State and PC registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // IF/ID payload: captured on response, valid cleared on consume or flush.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_if_valid   <= 1'b0;
            o_if_id_regs <= '0;
        end else if (if_load) begin
            o_if_valid   <= 1'b1;
            o_if_id_regs <= '{inst: imem.rsp_inst, pc: inflight_pc_q};
        end else if (if_clear) begin
            o_if_valid   <= 1'b0;
        end
    end

    // A response is only legal while a request is outstanding.
    assert property (@(posedge i_clk) disable iff (!i_rst)
        imem.rsp_valid |-> (state_q == WAIT || state_q == KILL))
        else $error("imem response with no outstanding request");

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_fetched      ((state_q == HOLD) && !i_stall && !i_flush_valid),
        .i_stalled      ((state_q == HOLD) && i_stall),
        .i_killed       (rsp_discard),
        .o_perf_fetched (o_perf_fetched),
        .o_perf_stall   (o_perf_stall),
        .o_perf_killed  (o_perf_killed)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: reset, basic fetch, stall hold, flush in
// every relevant state, PC wrap, mid-transaction reset and (with FETCH_PERF_EN)
// the performance counters.
module tb_fetch_ctrl;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] target = '0;
    logic        if_valid;
    logic        busy;
    if_id_regs_t regs;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_killed;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    fetch_ctrl_if #(.ADDR_W(32)) imem ();

    fetch_ctrl #(.XLEN(64), .RESET_PC(64'h0), .ADDR_W(32)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_stall        (stall),
        .i_flush_valid  (flush),
        .i_flush_target (target),
        .imem           (imem.master),
        .o_if_valid     (if_valid),
        .o_if_id_regs   (regs),
        .o_busy         (busy)
`ifdef FETCH_PERF_EN
        ,
        .o_perf_fetched (perf_fetched),
        .o_perf_stall   (perf_stall),
        .o_perf_killed  (perf_killed)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem.req_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        n_checks++;
        if (!ok) $display("FAIL %s: no request within 20 cycles", tag);
        else n_pass++;
    endtask

    task automatic rsp_pulse(input logic [31:0] inst);
        imem.rsp_valid = 1'b1;
        imem.rsp_inst  = inst;
        step();
        imem.rsp_valid = 1'b0;
        imem.rsp_inst  = '0;
    endtask

    task automatic test_reset();
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b0;
        imem.rsp_inst  = '0;
        rst_n = 1'b0;
        #12;
        n_checks++; if (imem.req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", imem.req_valid); else n_pass++;
        n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %b want 0", if_valid); else n_pass++;
        n_checks++; if (regs !== '0) $display("FAIL reset_regs: got %h want 0", regs); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem.req_valid !== 1'b0) $display("FAIL idle_req_valid: got %b want 0", imem.req_valid); else n_pass++;
        step();
        n_checks++; if (imem.req_valid !== 1'b1) $display("FAIL first_req_valid: got %b want 1", imem.req_valid); else n_pass++;
        n_checks++; if (imem.req_addr !== 32'h0) $display("FAIL first_req_addr: got %h want 0", imem.req_addr); else n_pass++;
    endtask

    task automatic test_basic();
        step();
        n_checks++; if (busy !== 1'b1 || imem.req_valid !== 1'b0) $display("FAIL basic_wait: busy %b req %b want 1 0", busy, imem.req_valid); else n_pass++;
        step();
        rsp_pulse(32'h0000_0013);
        n_checks++; if (if_valid !== 1'b1) $display("FAIL basic_if_valid: got %b want 1", if_valid); else n_pass++;
        n_checks++; if (regs.pc !== 64'h0) $display("FAIL basic_pc: got %h want 0", regs.pc); else n_pass++;
        n_checks++; if (regs.inst !== 32'h0000_0013) $display("FAIL basic_inst: got %h want 00000013", regs.inst); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_hold: got %b want 0", busy); else n_pass++;
        step();
        n_checks++; if (if_valid !== 1'b0) $display("FAIL basic_consume: if_valid %b want 0", if_valid); else n_pass++;
        n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h4) $display("FAIL basic_next_req: req %b addr %h want 1 00000004", imem.req_valid, imem.req_addr); else n_pass++;
    endtask

    task automatic test_stall();
        if_id_regs_t exp;
        exp = '{inst: 32'h00A0_0093, pc: 64'h4};
        stall = 1'b1;
        step();
        rsp_pulse(32'h00A0_0093);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (if_valid !== 1'b1 || regs !== exp || imem.req_valid !== 1'b0)
                $display("FAIL stall_hold_%0d: valid %b regs %h req %b want 1 %h 0", i, if_valid, regs, imem.req_valid, exp);
            else n_pass++;
            step();
        end
        stall = 1'b0;
        step();
        n_checks++; if (if_valid !== 1'b0) $display("FAIL stall_release_valid: got %b want 0", if_valid); else n_pass++;
        n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h8) $display("FAIL stall_next_req: req %b addr %h want 1 00000008", imem.req_valid, imem.req_addr); else n_pass++;
    endtask

    task automatic test_flush_wait();
        step();
        flush  = 1'b1;
        target = 64'h103;
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (busy !== 1'b1 || if_valid !== 1'b0 || imem.req_valid !== 1'b0)
                $display("FAIL kill_wait_%0d: busy %b valid %b req %b want 1 0 0", i, busy, if_valid, imem.req_valid);
            else n_pass++;
            if (i < 2) step();
        end
        rsp_pulse(32'hDEAD_BEEF);
        n_checks++; if (if_valid !== 1'b0) $display("FAIL kill_dropped: if_valid %b want 0", if_valid); else n_pass++;
        n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h100) $display("FAIL kill_next_req: req %b addr %h want 1 00000100", imem.req_valid, imem.req_addr); else n_pass++;
    endtask

    task automatic test_flush_handshake();
        flush  = 1'b1;
        target = 64'h200;
        step();
        flush = 1'b0;
        n_checks++; if (busy !== 1'b1 || imem.req_valid !== 1'b0) $display("FAIL hs_kill: busy %b req %b want 1 0", busy, imem.req_valid); else n_pass++;
        step();
        rsp_pulse(32'hBAD0_0000);
        n_checks++; if (if_valid !== 1'b0) $display("FAIL hs_dropped: if_valid %b want 0", if_valid); else n_pass++;
        n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h200) $display("FAIL hs_next_req: req %b addr %h want 1 00000200", imem.req_valid, imem.req_addr); else n_pass++;
        step();
        rsp_pulse(32'h1111_1111);
        n_checks++; if (if_valid !== 1'b1 || regs.pc !== 64'h200 || regs.inst !== 32'h1111_1111) $display("FAIL hs_refetch: valid %b pc %h inst %h want 1 200 11111111", if_valid, regs.pc, regs.inst); else n_pass++;
        step();
    endtask

    task automatic test_flush_req_noack();
        imem.req_ready = 1'b0;
        step();
        n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h204) $display("FAIL noack_hold: req %b addr %h want 1 00000204", imem.req_valid, imem.req_addr); else n_pass++;
        flush  = 1'b1;
        target = 64'h301;
        step();
        flush = 1'b0;
        n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h300 || busy !== 1'b0) $display("FAIL noack_redirect: req %b addr %h busy %b want 1 00000300 0", imem.req_valid, imem.req_addr, busy); else n_pass++;
        imem.req_ready = 1'b1;
    endtask

    task automatic test_flush_hold_stall();
        stall = 1'b1;
        step();
        rsp_pulse(32'h2222_2222);
        n_checks++; if (if_valid !== 1'b1 || regs.pc !== 64'h300) $display("FAIL hold_flush_pre: valid %b pc %h want 1 300", if_valid, regs.pc); else n_pass++;
        flush  = 1'b1;
        target = 64'h400;
        step();
        flush = 1'b0;
        stall = 1'b0;
        n_checks++; if (if_valid !== 1'b0) $display("FAIL hold_flush_drop: if_valid %b want 0", if_valid); else n_pass++;
        n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h400) $display("FAIL hold_flush_req: req %b addr %h want 1 00000400", imem.req_valid, imem.req_addr); else n_pass++;
    endtask

    task automatic test_flush_wait_rsp();
        step();
        imem.rsp_valid = 1'b1;
        imem.rsp_inst  = 32'h3333_3333;
        flush  = 1'b1;
        target = 64'h500;
        step();
        imem.rsp_valid = 1'b0;
        flush = 1'b0;
        n_checks++; if (if_valid !== 1'b0 || busy !== 1'b0) $display("FAIL wait_rsp_flush: valid %b busy %b want 0 0", if_valid, busy); else n_pass++;
        n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h500) $display("FAIL wait_rsp_flush_req: req %b addr %h want 1 00000500", imem.req_valid, imem.req_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        imem.req_ready = 1'b0;
        flush  = 1'b1;
        target = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        flush = 1'b0;
        imem.req_ready = 1'b1;
        n_checks++; if (imem.req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", imem.req_addr); else n_pass++;
        step();
        rsp_pulse(32'h4444_4444);
        n_checks++; if (regs.pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_pc: got %h want fffffffffffffffc", regs.pc); else n_pass++;
        step();
        n_checks++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h0) $display("FAIL wrap_next: req %b addr %h want 1 00000000", imem.req_valid, imem.req_addr); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        step();
        n_checks++; if (busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b want 1", busy); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem.req_valid !== 1'b0 || if_valid !== 1'b0 || busy !== 1'b0 || regs !== '0) $display("FAIL midrst_outputs: req %b valid %b busy %b regs %h want all 0", imem.req_valid, if_valid, busy, regs); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_req("midrst_req");
        n_checks++; if (imem.req_addr !== 32'h0) $display("FAIL midrst_addr: got %h want 0", imem.req_addr); else n_pass++;
    endtask

`ifdef FETCH_PERF_EN
    task automatic perf_fetch(input int stall_cycles);
        wait_req("perf_req");
        step();
        rsp_pulse(32'h0000_0013);
        if (stall_cycles > 0) begin
            stall = 1'b1;
            repeat (stall_cycles) step();
            stall = 1'b0;
        end
        step();
    endtask

    task automatic test_perf();
        wait_req("perf_kill_req");
        step();
        flush  = 1'b1;
        target = 64'h0;
        step();
        flush = 1'b0;
        rsp_pulse(32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) perf_fetch((i == 3) ? 4 : 0);
        n_checks++; if (perf_fetched !== 32'd10) $display("FAIL perf_fetched: got %0d want 10", perf_fetched); else n_pass++;
        n_checks++; if (perf_stall !== 32'd4) $display("FAIL perf_stall: got %0d want 4", perf_stall); else n_pass++;
        n_checks++; if (perf_killed !== 32'd1) $display("FAIL perf_killed: got %0d want 1", perf_killed); else n_pass++;
        force dut.u_perf.fetched_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_perf.fetched_q;
        perf_fetch(0);
        n_checks++; if (perf_fetched !== 32'd0) $display("FAIL perf_wrap: got %0d want 0", perf_fetched); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush_wait();
        test_flush_handshake();
        test_flush_req_noack();
        test_flush_hold_stall();
        test_flush_wait_rsp();
        test_wrap();
        test_reset_mid_wait();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
